// File: rtl/serword_rx.sv
// Receive-side deserializer for the counter-snapshot serial link: rebuilds MSB-first
// words from an oversampled bit clock and reports the mod-2^WIDTH delta to the previous word.
//
// state | meaning
// HUNT  | after reset, wait for an idle gap before trusting bit edges
// IDLE  | between frames, next edge starts a word
// RECV  | shifting bits in, counting to WIDTH
// DONE  | word delivered, expecting an idle gap
// ERR   | overlong frame, ignore edges until an idle gap
module serword_rx #(
  parameter int WIDTH = 30,
  parameter int GAP   = 4096,
  parameter int CW    = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             sdin,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] delta,
  output logic             valid,
  output logic             first,
  output logic             ferr
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {HUNT, IDLE, RECV, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic             sc_s1, sc_s2, sc_s3, sd_s1, sd_s2;
  logic             sedge, gap;
  logic [CW-1:0]    gcnt;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] prev, assembled;
  logic             seen;
  logic             start, shift, complete, ferr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_s1 <= 1'b0;
      sc_s2 <= 1'b0;
      sc_s3 <= 1'b0;
      sd_s1 <= 1'b0;
      sd_s2 <= 1'b0;
    end else begin
      sc_s1 <= sclk;
      sc_s2 <= sc_s1;
      sc_s3 <= sc_s2;
      sd_s1 <= sdin;
      sd_s2 <= sd_s1;
    end
  end

  assign sedge = sc_s2 & ~sc_s3;

  // Counter saturates at GAP so the terminal compare at GAP-1 fires once per idle period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  gcnt <= '0;
    else if (sedge)             gcnt <= '0;
    else if (gcnt != CW'(GAP))  gcnt <= gcnt + 1'b1;
  end

  assign gap       = (gcnt == CW'(GAP - 1)) & ~sedge;
  assign assembled = {shreg, sd_s2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (gap) state_nxt = IDLE;
      IDLE: if (sedge) state_nxt = RECV;
      RECV: begin
        if (sedge && bitcnt == BW'(WIDTH - 1)) state_nxt = DONE;
        else if (gap)                          state_nxt = IDLE;
      end
      DONE: begin
        if (gap)        state_nxt = IDLE;
        else if (sedge) state_nxt = ERR;
      end
      ERR:  if (gap) state_nxt = IDLE;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) & sedge;
    shift    = (state == RECV) & sedge;
    complete = shift & (bitcnt == BW'(WIDTH - 1));
    ferr_nxt = ((state == RECV) & gap) | ((state == DONE) & sedge);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      prev   <= '0;
      word   <= '0;
      delta  <= '0;
      valid  <= 1'b0;
      first  <= 1'b0;
      ferr   <= 1'b0;
      seen   <= 1'b0;
    end else begin
      valid <= complete;
      first <= complete & ~seen;
      ferr  <= ferr_nxt;
      if (start) begin
        shreg  <= {{(WIDTH-2){1'b0}}, sd_s2};
        bitcnt <= BW'(1);
      end else if (shift) begin
        shreg  <= assembled[WIDTH-2:0];
        bitcnt <= bitcnt + 1'b1;
      end
      if (complete) begin
        word  <= assembled;
        delta <= assembled - prev;
        prev  <= assembled;
        seen  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serword_rx.sv
// Randomized scoreboard bench for serword_rx: a frame-level reference model predicts
// each valid/ferr pulse, and a monitor pops and compares them as the DUT produces them.
module tb_serword_rx;

  localparam int WIDTH = 30;
  localparam int GAP   = 200;
  localparam int CW    = 8;
  localparam int IDLE_CYC = GAP + 30;

  typedef struct packed {
    logic             isv;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] d;
    logic             f;
  } ev_t;

  logic             clk, rst, sclk, sdin;
  logic [WIDTH-1:0] word, delta;
  logic             valid, first, ferr;

  ev_t              exp_q[$];
  int               checks, failures;
  logic [WIDTH-1:0] m_last_w, m_last_d;
  bit               m_seen;

  serword_rx #(.WIDTH(WIDTH), .GAP(GAP), .CW(CW)) dut (
    .clk(clk), .reset(rst), .sclk(sclk), .sdin(sdin),
    .word(word), .delta(delta), .valid(valid), .first(first), .ferr(ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Frame-level model: n bits MSB first; first WIDTH bits form the word.
  task automatic model_frame(input logic [63:0] v, input int n);
    logic [WIDTH-1:0] w;
    if (n < WIDTH) begin
      exp_q.push_back('{1'b0, m_last_w, m_last_d, 1'b0});
    end else begin
      w = WIDTH'(v >> (n - WIDTH));
      m_last_d = w - m_last_w;
      m_last_w = w;
      exp_q.push_back('{1'b1, w, m_last_d, !m_seen});
      m_seen = 1'b1;
      if (n > WIDTH) exp_q.push_back('{1'b0, m_last_w, m_last_d, 1'b0});
    end
  endtask

  task automatic model_reset();
    m_last_w = '0;
    m_last_d = '0;
    m_seen   = 1'b0;
  endtask

  task automatic send(input logic [63:0] v, input int n, input bit jit, input bit do_model);
    int lo, hi;
    if (do_model) model_frame(v, n);
    for (int i = n - 1; i >= 0; i--) begin
      sdin = v[i];
      lo = jit ? 3 + int'($urandom_range(2)) : 32;
      hi = jit ? 3 + int'($urandom_range(2)) : 32;
      wait_cyc(lo);
      sclk = 1'b1;
      wait_cyc(hi);
      sclk = 1'b0;
    end
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (valid || ferr)) begin
        checks++;
        if (valid && ferr) begin
          failures++;
          $display("FAIL both_pulses valid=%0b ferr=%0b required one", valid, ferr);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse valid=%0b ferr=%0b word=0x%0h required none", valid, ferr, word);
        end else begin
          e = exp_q.pop_front();
          if (valid !== e.isv || word !== e.w || delta !== e.d || (valid && first !== e.f)) begin
            failures++;
            $display("FAIL pulse actual valid=%0b word=0x%0h delta=0x%0h first=%0b required valid=%0b word=0x%0h delta=0x%0h first=%0b",
                     valid, word, delta, first, e.isv, e.w, e.d, e.f);
          end
        end
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    checks = 0;
    failures = 0;
    model_reset();
    rst = 1'b1;
    sclk = 1'b0;
    sdin = 1'b0;
    fork
      monitor();
    join_none
    wait_cyc(5);
    chk("reset_word", 64'(word), 64'h0);
    chk("reset_delta", 64'(delta), 64'h0);
    chk("reset_valid", 64'(valid), 64'h0);
    chk("reset_first", 64'(first), 64'h0);
    chk("reset_ferr", 64'(ferr), 64'h0);
    rst = 1'b0;
    wait_cyc(GAP + 10);

    send(64'h2AAAAAAA, 30, 1'b0, 1'b1); wait_cyc(IDLE_CYC);
    send(64'h2AAAAAB4, 30, 1'b0, 1'b1); wait_cyc(IDLE_CYC);
    send(64'h3FFFFFF0, 30, 1'b0, 1'b1); wait_cyc(IDLE_CYC);
    send(64'h00000010, 30, 1'b0, 1'b1); wait_cyc(IDLE_CYC);
    send(64'h0000A5C, 12, 1'b0, 1'b1);  wait_cyc(IDLE_CYC);
    send({31'h0, 30'h12345678, 1'b1}, 31, 1'b0, 1'b1); wait_cyc(IDLE_CYC);
    send(64'h0ABCDEF0, 30, 1'b0, 1'b1); wait_cyc(IDLE_CYC);
    chk("drain_before_reset", 64'(exp_q.size()), 64'h0);

    // Reset in the middle of a frame; the tail must be ignored while hunting.
    send(64'h15555555 >> 15, 15, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    wait_cyc(3);
    chk("midreset_word", 64'(word), 64'h0);
    chk("midreset_delta", 64'(delta), 64'h0);
    rst = 1'b0;
    send(64'h15555555 & 64'h7FFF, 15, 1'b0, 1'b0);
    wait_cyc(IDLE_CYC);
    send(64'h00001234, 30, 1'b0, 1'b1); wait_cyc(IDLE_CYC);

    for (int k = 0; k < 100; k++) begin
      rv = WIDTH'($urandom);
      if (k % 4 == 1) rv = m_last_w + WIDTH'($urandom_range(255));
      send(64'(rv), 30, 1'b1, 1'b1);
      wait_cyc(IDLE_CYC);
    end

    chk("drain_final", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serword_rx.md
# serword_rx

Receive-side deserializer for the counter-snapshot serial link. It samples an external bit clock and serial data line in a single fast clock domain and reassembles each WIDTH-bit word, sent MSB first. It also produces the modulo-2^WIDTH difference from the previous word, so the next stage reads counts-per-frame directly. It sits directly downstream of the parallel-load shift-register transmitter and consumes its bit clock and data output.

## Interface
- WIDTH, 30: word length in bits; must equal the transmitter word length.
- GAP, 4096: number of consecutive clk cycles with no bit-clock rising edge that marks a frame boundary.
  - Must exceed the longest bit period in clk cycles.
  - Must be shorter than the inter-frame idle time.
- CW, 13: width of the gap counter; must satisfy 2^CW > GAP.

- clk, input, 1: sampling clock; all logic on its posedge.
- reset, input, 1: asynchronous, active-high reset.
- sclk, input, 1: serial bit clock, asynchronous to clk; data is valid at its rising edge.
- sdin, input, 1: serial data, asynchronous to clk, MSB first.
- word, output, WIDTH: last complete word received.
- delta, output, WIDTH: word minus previous word, mod 2^WIDTH.
- valid, output, 1: one-cycle pulse when word and delta update.
- first, output, 1: qualifies valid; set if this is the first word since reset (delta = word).
- ferr, output, 1: one-cycle pulse on a framing error.

## Operation
- **Synchronizers:** sclk and sdin each pass through two flops (s1, s2). A third flop s3 on sclk gives edge = s2 & ~s3. Data is taken from the sdin s2 flop in the edge cycle.
- **Gap counter:** cleared to 0 on edge, otherwise increments and saturates at GAP. gap = (counter == GAP-1) & ~edge, true for exactly one cycle per idle period.
- **State machine (HUNT, IDLE, RECV, DONE, ERR):**
  - HUNT (reset state): edges ignored; gap -> IDLE. Prevents locking mid-frame.
  - IDLE: edge -> shift bit in, bitcnt=1, RECV.
  - RECV: edge -> shift (shreg <= {shreg[WIDTH-2:0], bit}), bitcnt++.
    - When the shift brings bitcnt to WIDTH: word <= assembled value, delta <= assembled - prev, prev <= assembled, valid <= 1, go to DONE.
    - gap before WIDTH bits -> ferr pulse, IDLE, partial word discarded.
  - DONE: gap -> IDLE; edge -> ferr pulse, ERR.
  - ERR: edges ignored; gap -> IDLE.
- **Arithmetic:** delta is a WIDTH-bit unsigned subtract, with wrap-around discarded.
  - prev is 0 after reset, so the first delta equals word.
  - first <= 1 with the first valid after reset; 0 on all later valids.
- word and delta hold until the next valid. valid, first, and ferr are low except on their pulse cycle.
- **Simultaneous edge and gap:** impossible by construction, since edge clears the counter and gap requires ~edge.
- **Reset (any time, including mid-frame):** immediately forces HUNT, bitcnt=0, gap counter=0, shreg=0, prev=0, all sync flops 0.

## Timing
- Reset values: word=0, delta=0, valid=0, first=0, ferr=0.
- **Input requirements:**
  - sclk high ≥3 clk cycles and low ≥3 clk cycles.
  - sdin stable from 3 clk before to 3 clk after each sclk rising edge.
- **Latency:**
  - sclk rise captured by s1 at clk edge k -> edge asserted in cycle k+1..k+2.
  - valid/ferr registered high after clk edge k+2 and low after k+3.
  - word, delta, and first change on the same edge valid rises.
- Frame boundary is detected GAP cycles after the last edge, plus 2 cycles of sync latency.
- Throughput: one word per frame; valid pulses are never closer together than WIDTH bit periods plus GAP.

## Test plan
- **First word:** reset, idle ≥GAP+4 cycles, send 0x2AAAAAAA over 30 sclk periods (period 64 clk, GAP=200).
  - Expect valid for exactly one cycle, 3 clk after the 30th rise reaches s1.
  - word=0x2AAAAAAA, delta=0x2AAAAAAA, first=1.
- **Second word:** gap, then send 0x2AAAAAB4.
  - Expect word=0x2AAAAAB4, delta=0x0000000A, first=0, ferr never asserted.
- **Wrap-around:** send 0x3FFFFFF0, then 0x00000010.
  - Expect second delta=0x00000020.
- **Short and long frames:**
  - 12 bits then gap -> one ferr pulse after the gap, no valid, word unchanged.
  - 31 bits -> valid on bit 30, ferr on bit 31; the following normal frame is received correctly.
- **Reset and mid-frame join:**
  - Assert reset after 15 bits of a frame, release, and the remaining 15 bits arrive.
  - Expect no valid and no ferr (HUNT ignores them); after the gap, the next frame 0x00001234 gives valid, word=delta=0x00001234, first=1.
- **Synchronizer tolerance:** jitter sclk and sdin arrival by ±1 clk relative to clk within the spec'd stability window.
  - Expect all words bit-exact across 100 random frames; delta checked against a reference model.
